// File: rtl/bram_test_pkg.sv
// Shared definitions for the BRAM read-modify-write-verify engine.
// Holds the controller state encoding and the transform mode selectors.
package bram_test_pkg;

    // Controller states; each word walks RD -> CAP -> WR -> VR -> CHK.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        VR   = 3'd4,
        CHK  = 3'd5,
        DONE = 3'd6
    } state_t;

    // Transform selectors for the MODE parameter.
    localparam int MODE_INC = 0;
    localparam int MODE_INV = 1;
    localparam int MODE_PAT = 2;

endpackage

// File: rtl/bram_test_transform.sv
// Combinational word transform used to derive the value written back.
// Ports:
//   i_orig      - original word read from the BRAM
//   o_expected  - transformed word (increment, invert or fixed pattern)
module bram_test_transform
    import bram_test_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MODE       = MODE_INC,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 16'hA5A5
) (
    input  logic [DATA_WIDTH-1:0] i_orig,
    output logic [DATA_WIDTH-1:0] o_expected
);

    // Select the transform; increment wraps naturally at the word width.
    always_comb begin
        o_expected = i_orig;
        case (MODE)
            MODE_INC: o_expected = i_orig + DATA_WIDTH'(1);
            MODE_INV: o_expected = ~i_orig;
            MODE_PAT: o_expected = PATTERN;
            default:  o_expected = i_orig;
        endcase
    end

endmodule

// File: rtl/bram_test_engine.sv
// Self-sequencing read-modify-write-verify engine for a dual-port BRAM.
// For every address in START_ADDR..END_ADDR it reads the word on port A,
// writes the transformed word on port A, reads it back on port B and
// compares, accumulating an error count and the first failing address.
// Ports:
//   I_CLK, I_NRESET            - clock, asynchronous active-low reset
//   I_START                    - start request (honoured in IDLE/DONE only)
//   O_BUSY, O_DONE, O_PASS     - run status
//   O_ERROR_COUNT              - number of words that failed verify
//   O_FIRST_FAIL_ADDR          - address of the first miscompare (0 if none)
//   O_ADDRESS_A, O_DATA_A,
//   O_WRITE_ENABLE_A, I_DATA_A - BRAM port A (read/write)
//   O_ADDRESS_B, I_DATA_B      - BRAM port B (read only)
module bram_test_engine
    import bram_test_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    START_ADDR = 0,
    parameter int                    END_ADDR   = 15,
    parameter int                    MODE       = MODE_INC,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 16'hA5A5
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    input  logic                  I_START,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic                  O_PASS,
    output logic [ADDR_WIDTH:0]   O_ERROR_COUNT,
    output logic [ADDR_WIDTH-1:0] O_FIRST_FAIL_ADDR,
    output logic [ADDR_WIDTH-1:0] O_ADDRESS_A,
    output logic [DATA_WIDTH-1:0] O_DATA_A,
    output logic                  O_WRITE_ENABLE_A,
    input  logic [DATA_WIDTH-1:0] I_DATA_A,
    output logic [ADDR_WIDTH-1:0] O_ADDRESS_B,
    input  logic [DATA_WIDTH-1:0] I_DATA_B
);

    // Reject address ranges the engine cannot walk and unknown modes.
    if ((END_ADDR < START_ADDR) || (START_ADDR < 0) ||
        (longint'(END_ADDR) >= (longint'(1) << ADDR_WIDTH))) begin : g_bad_range
        $fatal(1, "bram_test_engine: illegal START_ADDR/END_ADDR range");
    end
    if ((MODE < MODE_INC) || (MODE > MODE_PAT)) begin : g_bad_mode
        $fatal(1, "bram_test_engine: illegal MODE");
    end

    localparam logic [ADDR_WIDTH-1:0] LP_START = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_END   = ADDR_WIDTH'(END_ADDR);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cur_addr,  w_cur_addr_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr_a,    w_addr_a_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr_b,    w_addr_b_nxt;
    // The port A write-data register doubles as the expected-value store:
    // it is loaded once per word in CAP and compared against in CHK.
    logic [DATA_WIDTH-1:0]   r_data_a,    w_data_a_nxt;
    logic                    r_we_a,      w_we_a_nxt;
    logic                    r_busy,      w_busy_nxt;
    logic                    r_done,      w_done_nxt;
    logic                    r_pass,      w_pass_nxt;
    logic [ADDR_WIDTH:0]     r_err_cnt,   w_err_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   r_ffa,       w_ffa_nxt;
    logic [DATA_WIDTH-1:0]   w_expected;
    logic                    w_miscompare;

    bram_test_transform #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODE       (MODE),
        .PATTERN    (PATTERN)
    ) u_transform (
        .i_orig     (I_DATA_A),
        .o_expected (w_expected)
    );

    assign w_miscompare = (I_DATA_B != r_data_a);

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so BRAM addresses are already on the pins in RD and VR.
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_addr_a_nxt   = r_addr_a;
        w_addr_b_nxt   = r_addr_b;
        w_data_a_nxt   = r_data_a;
        w_we_a_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_err_cnt_nxt  = r_err_cnt;
        w_ffa_nxt      = r_ffa;
        case (r_state)
            IDLE, DONE: begin
                if (I_START) begin
                    w_state_nxt    = RD;
                    w_cur_addr_nxt = LP_START;
                    w_addr_a_nxt   = LP_START;
                    w_err_cnt_nxt  = '0;
                    w_ffa_nxt      = '0;
                    w_pass_nxt     = 1'b0;
                end else begin
                    w_state_nxt    = r_state;
                end
            end
            RD: w_state_nxt = CAP;
            CAP: begin
                // Read data for the RD address is valid during this cycle.
                w_state_nxt  = WR;
                w_data_a_nxt = w_expected;
                w_we_a_nxt   = 1'b1;
            end
            WR: begin
                w_state_nxt  = VR;
                w_addr_b_nxt = r_cur_addr;
            end
            VR: w_state_nxt = CHK;
            CHK: begin
                if (w_miscompare) begin
                    if (r_err_cnt == '0) begin
                        w_ffa_nxt = r_cur_addr;
                    end else begin
                        w_ffa_nxt = r_ffa;
                    end
                    w_err_cnt_nxt = r_err_cnt + (ADDR_WIDTH+1)'(1);
                end else begin
                    w_err_cnt_nxt = r_err_cnt;
                end
                if (r_cur_addr == LP_END) begin
                    w_state_nxt = DONE;
                    w_pass_nxt  = (w_err_cnt_nxt == '0);
                end else begin
                    w_state_nxt    = RD;
                    w_cur_addr_nxt = r_cur_addr + ADDR_WIDTH'(1);
                    w_addr_a_nxt   = r_cur_addr + ADDR_WIDTH'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // State and output registers; reset clears everything, including the
    // write enable, without waiting for a clock edge.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_state    <= IDLE;
            r_cur_addr <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_data_a   <= '0;
            r_we_a     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_ffa      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_addr_a   <= w_addr_a_nxt;
            r_addr_b   <= w_addr_b_nxt;
            r_data_a   <= w_data_a_nxt;
            r_we_a     <= w_we_a_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_ffa      <= w_ffa_nxt;
        end
    end

    assign O_BUSY            = r_busy;
    assign O_DONE            = r_done;
    assign O_PASS            = r_pass;
    assign O_ERROR_COUNT     = r_err_cnt;
    assign O_FIRST_FAIL_ADDR = r_ffa;
    assign O_ADDRESS_A       = r_addr_a;
    assign O_DATA_A          = r_data_a;
    assign O_WRITE_ENABLE_A  = r_we_a;
    assign O_ADDRESS_B       = r_addr_b;

endmodule

// File: tb/tb_bram_test_engine.sv
// Bench for bram_test_engine: three engines (increment, invert with
// injected read faults, single-word pattern) each beside its own BRAM model.
`timescale 1ns/1ps
module tb_bram_test_engine;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]    rst_n_v;
    logic [2:0]    start_v;
    logic          busy_v   [3];
    logic          done_v   [3];
    logic          pass_v   [3];
    logic          we_v     [3];
    logic [AW:0]   ec_v     [3];
    logic [AW-1:0] ffa_v    [3];
    logic [AW-1:0] addr_a_v [3];
    logic [AW-1:0] addr_b_v [3];
    logic [DW-1:0] data_a_v [3];
    logic [DW-1:0] rd_a_v   [3];
    logic [DW-1:0] rd_b_v   [3];

    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    logic [DW-1:0] mem2 [0:1023];
    logic          pl_we [3];
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            we_cnt2 = 0;

    int n_tests = 0;
    int n_fail  = 0;

    bram_test_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(0), .END_ADDR(15),
                       .MODE(0), .PATTERN(16'hA5A5)) u_dut0 (
        .I_CLK(clk), .I_NRESET(rst_n_v[0]), .I_START(start_v[0]),
        .O_BUSY(busy_v[0]), .O_DONE(done_v[0]), .O_PASS(pass_v[0]),
        .O_ERROR_COUNT(ec_v[0]), .O_FIRST_FAIL_ADDR(ffa_v[0]),
        .O_ADDRESS_A(addr_a_v[0]), .O_DATA_A(data_a_v[0]), .O_WRITE_ENABLE_A(we_v[0]),
        .I_DATA_A(rd_a_v[0]), .O_ADDRESS_B(addr_b_v[0]), .I_DATA_B(rd_b_v[0]));

    bram_test_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(0), .END_ADDR(15),
                       .MODE(1), .PATTERN(16'hA5A5)) u_dut1 (
        .I_CLK(clk), .I_NRESET(rst_n_v[1]), .I_START(start_v[1]),
        .O_BUSY(busy_v[1]), .O_DONE(done_v[1]), .O_PASS(pass_v[1]),
        .O_ERROR_COUNT(ec_v[1]), .O_FIRST_FAIL_ADDR(ffa_v[1]),
        .O_ADDRESS_A(addr_a_v[1]), .O_DATA_A(data_a_v[1]), .O_WRITE_ENABLE_A(we_v[1]),
        .I_DATA_A(rd_a_v[1]), .O_ADDRESS_B(addr_b_v[1]), .I_DATA_B(rd_b_v[1]));

    bram_test_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(7), .END_ADDR(7),
                       .MODE(2), .PATTERN(16'hA5A5)) u_dut2 (
        .I_CLK(clk), .I_NRESET(rst_n_v[2]), .I_START(start_v[2]),
        .O_BUSY(busy_v[2]), .O_DONE(done_v[2]), .O_PASS(pass_v[2]),
        .O_ERROR_COUNT(ec_v[2]), .O_FIRST_FAIL_ADDR(ffa_v[2]),
        .O_ADDRESS_A(addr_a_v[2]), .O_DATA_A(data_a_v[2]), .O_WRITE_ENABLE_A(we_v[2]),
        .I_DATA_A(rd_a_v[2]), .O_ADDRESS_B(addr_b_v[2]), .I_DATA_B(rd_b_v[2]));

    // BRAM models: synchronous read, one cycle latency, bench preload port.
    always @(posedge clk) begin
        if (pl_we[0]) mem0[pl_addr] <= pl_data;
        else if (we_v[0]) mem0[addr_a_v[0]] <= data_a_v[0];
        rd_a_v[0] <= mem0[addr_a_v[0]];
        rd_b_v[0] <= mem0[addr_b_v[0]];
    end

    // Model 1 reads bit 0 stuck at 1 on port B at addresses 5 and 9.
    always @(posedge clk) begin
        if (pl_we[1]) mem1[pl_addr] <= pl_data;
        else if (we_v[1]) mem1[addr_a_v[1]] <= data_a_v[1];
        rd_a_v[1] <= mem1[addr_a_v[1]];
        if (addr_b_v[1] == 10'd5 || addr_b_v[1] == 10'd9)
            rd_b_v[1] <= mem1[addr_b_v[1]] | 16'h0001;
        else
            rd_b_v[1] <= mem1[addr_b_v[1]];
    end

    always @(posedge clk) begin
        if (pl_we[2]) mem2[pl_addr] <= pl_data;
        else if (we_v[2]) mem2[addr_a_v[2]] <= data_a_v[2];
        rd_a_v[2] <= mem2[addr_a_v[2]];
        rd_b_v[2] <= mem2[addr_b_v[2]];
        if (we_v[2]) we_cnt2 <= we_cnt2 + 1;
    end

    typedef struct {
        int   t0;
        int   cycles;
        logic pass;
        int   errs;
        int   ffa;
    } exp_t;

    exp_t sbq [3][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_run(input int d, input int t0, input int cycles,
                              input logic pass, input int errs, input int ffa);
        exp_t e;
        e.t0 = t0; e.cycles = cycles; e.pass = pass; e.errs = errs; e.ffa = ffa;
        sbq[d].push_back(e);
    endtask

    // Monitor: on each rising O_DONE pop the next expected run and compare.
    logic done_prev [3];
    initial begin
        exp_t e;
        for (int d = 0; d < 3; d++) done_prev[d] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (done_v[d] && !done_prev[d]) begin
                    if (sbq[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected done: got done=1, expected no run pending", d);
                    end else begin
                        e = sbq[d].pop_front();
                        chk($sformatf("dut%0d run cycles", d), 32'(cyc - e.t0), 32'(e.cycles));
                        chk($sformatf("dut%0d pass", d), 32'(pass_v[d]), 32'(e.pass));
                        chk($sformatf("dut%0d error count", d), 32'(ec_v[d]), 32'(e.errs));
                        chk($sformatf("dut%0d first fail addr", d), 32'(ffa_v[d]), 32'(e.ffa));
                    end
                end
                done_prev[d] = done_v[d];
            end
        end
    end

    task automatic preload(input int d, input int a, input logic [DW-1:0] v);
        pl_we[d] = 1'b1;
        pl_addr  = AW'(a);
        pl_data  = v;
        @(negedge clk);
        pl_we[d] = 1'b0;
    endtask

    task automatic do_start(input int d, output int t0);
        @(negedge clk);
        start_v[d] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_sb(input int d);
        int n = 0;
        while (sbq[d].size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sbq[d].size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d done timeout: waited %0d cycles, expected done earlier", d, n);
            sbq[d].delete();
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s dut%0d busy", tag, d),   32'(busy_v[d]), 32'd0);
        chk($sformatf("%s dut%0d done", tag, d),   32'(done_v[d]), 32'd0);
        chk($sformatf("%s dut%0d pass", tag, d),   32'(pass_v[d]), 32'd0);
        chk($sformatf("%s dut%0d errcnt", tag, d), 32'(ec_v[d]), 32'd0);
        chk($sformatf("%s dut%0d ffa", tag, d),    32'(ffa_v[d]), 32'd0);
        chk($sformatf("%s dut%0d addr_a", tag, d), 32'(addr_a_v[d]), 32'd0);
        chk($sformatf("%s dut%0d addr_b", tag, d), 32'(addr_b_v[d]), 32'd0);
        chk($sformatf("%s dut%0d data_a", tag, d), 32'(data_a_v[d]), 32'd0);
        chk($sformatf("%s dut%0d we", tag, d),     32'(we_v[d]), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int found;
        start_v = 3'b000;
        rst_n_v = 3'b000;
        for (int d = 0; d < 3; d++) pl_we[d] = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_zero(d, "reset");
        rst_n_v = 3'b111;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            preload(0, i, 16'(i));
            preload(1, i, 16'h8001 | 16'(i << 4));
            preload(2, i, 16'h1230 + 16'(i));
        end

        // Increment over 0x0000..0x000F.
        do_start(0, t0);
        expect_run(0, t0, 81, 1'b1, 0, 0);
        wait_sb(0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("inc mem0[%0d]", i), 32'(mem0[i]), 32'(i + 1));

        // Wrap of 0xFFFF, restart from DONE, extra start while busy.
        @(negedge clk);
        preload(0, 3, 16'hFFFF);
        do_start(0, t0);
        chk("restart busy", 32'(busy_v[0]), 32'd1);
        chk("restart done", 32'(done_v[0]), 32'd0);
        chk("restart addr_a", 32'(addr_a_v[0]), 32'd0);
        expect_run(0, t0, 81, 1'b1, 0, 0);
        repeat (20) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_sb(0);
        chk("wrap mem0[3]", 32'(mem0[3]), 32'h0000);
        chk("inc2 mem0[0]", 32'(mem0[0]), 32'h0002);
        chk("inc2 mem0[15]", 32'(mem0[15]), 32'h0011);

        // Invert with two faulty verify reads, then rerun from DONE.
        do_start(1, t0);
        expect_run(1, t0, 81, 1'b0, 2, 5);
        wait_sb(1);
        chk("inv mem1[5]", 32'(mem1[5]), 32'h7FAE);
        chk("inv mem1[9]", 32'(mem1[9]), 32'h7F6E);
        do_start(1, t0);
        chk("rerun cleared errcnt", 32'(ec_v[1]), 32'd0);
        chk("rerun cleared ffa", 32'(ffa_v[1]), 32'd0);
        chk("rerun busy", 32'(busy_v[1]), 32'd1);
        expect_run(1, t0, 81, 1'b1, 0, 0);
        wait_sb(1);
        chk("reinv mem1[5]", 32'(mem1[5]), 32'h8051);

        // Single-word pattern write at address 7.
        do_start(2, t0);
        expect_run(2, t0, 6, 1'b1, 0, 0);
        wait_sb(2);
        chk("pat mem2[7]", 32'(mem2[7]), 32'hA5A5);
        chk("pat mem2[6]", 32'(mem2[6]), 32'h1236);
        chk("pat mem2[8]", 32'(mem2[8]), 32'h1238);
        chk("pat we pulses", 32'(we_cnt2), 32'd1);

        // Reset during the write of address 4.
        do_start(0, t0);
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            @(posedge clk);
            #1;
            if (we_v[0] && addr_a_v[0] == 10'd4) found = 1;
        end
        chk("reached WR of addr 4", 32'(found), 32'd1);
        rst_n_v[0] = 1'b0;
        #1;
        chk_zero(0, "midreset");
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("partial mem0[3]", 32'(mem0[3]), 32'h0001);
        chk("partial mem0[4]", 32'(mem0[4]), 32'h0006);
        do_start(0, t0);
        expect_run(0, t0, 81, 1'b1, 0, 0);
        wait_sb(0);
        chk("clean mem0[0]", 32'(mem0[0]), 32'h0004);
        chk("clean mem0[3]", 32'(mem0[3]), 32'h0002);
        chk("clean mem0[4]", 32'(mem0[4]), 32'h0007);
        chk("clean mem0[15]", 32'(mem0[15]), 32'h0012);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
